// File: rtl/psum_neuron_acc_if.sv
// rtl/psum_neuron_acc_if.sv - packet link bundle for the neuron accumulator stage
//
// Carries both packet streams of psum_neuron_acc:
//   in_data/in_valid/in_ready    : psum and residual packets arriving from the NoC
//   out_data/out_valid/out_ready : spike and residual packets leaving toward OFM memory
// Modports:
//   master : the side that drives packets in and consumes packets out
//   slave  : the neuron accumulator itself
interface psum_neuron_acc_if #(
    parameter int WIDTH = 35
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/psum_neuron_acc.sv
// rtl/psum_neuron_acc.sv - integrate-and-fire neuron stage feeding OFM/residual memory
//
// Collects the three partial sums (SUM1/SUM2/SUM3) for one output pixel plus,
// after the first timestep, the stored residual from OFM memory. The sum is
// compared against THRESHOLD; a spike packet and then a residual packet are
// sent toward OFM memory. Pixels are walked in raster order, timestep by
// timestep, until the last pixel of the last timestep, after which the block
// parks in DONE until reset.
//
// Packet layout: [34:31] dest, [30:27] src, [26:25] type, [24:8] aux, [7:0] value
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   bus        psum_neuron_acc_if.slave (in_data/in_valid/in_ready,
//              out_data/out_valid/out_ready)
//   pix_idx    current pixel index (row*COLS+col)
//   tstep      current timestep
//   done       high once the last pixel of the last timestep is sent
//   err_pulse  one-cycle pulse when an incoming packet is dropped
//
// Optional build macro: NEURON_LEAK_EN - subtract LEAK (floored at 0) from the
// accumulator before the threshold compare.
module psum_neuron_acc #(
    parameter int          WIDTH      = 35,
    parameter int          ROWS       = 28,
    parameter int          COLS       = 28,
    parameter int          TIMESTEPS  = 10,
    parameter int          THRESHOLD  = 64,
    parameter logic [3:0]  SELF_ADDR  = 4'b1000,
    parameter logic [3:0]  OFM_ADDR   = 4'b1100,
    parameter logic [3:0]  SUM1_ADDR  = 4'b0001,
    parameter logic [3:0]  SUM2_ADDR  = 4'b0011,
    parameter logic [3:0]  SUM3_ADDR  = 4'b0111,
    parameter logic [1:0]  PSUM_TYPE  = 2'b01,
    parameter logic [1:0]  RES_TYPE   = 2'b10,
    parameter logic [1:0]  SPIKE_TYPE = 2'b11,
    parameter int          LEAK       = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    psum_neuron_acc_if.slave    bus,
    output logic [9:0]          pix_idx,
    output logic [3:0]          tstep,
    output logic                done,
    output logic                err_pulse
);

`ifdef NEURON_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    // With the leak disabled the amount is zero, which makes acc_eff == acc.
    localparam logic [9:0] LEAK_AMT = LEAK_ON ? 10'(LEAK) : 10'd0;
    localparam logic [9:0] THR      = 10'(THRESHOLD);
    localparam logic [9:0] PIX_LAST = 10'(ROWS * COLS - 1);
    localparam logic [3:0] TS_LAST  = 4'(TIMESTEPS - 1);

    typedef enum logic [2:0] {
        COLLECT,
        FIRE,
        SEND_SPK,
        SEND_RES,
        DONE_ST
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [3:0]  got_mask;
    logic [9:0]  acc;
    logic        spike;
    logic [7:0]  resid;

    // ------------------------------------------------------------------
    // Incoming packet decode
    // ------------------------------------------------------------------
    logic [3:0]  in_dest;
    logic [3:0]  in_src;
    logic [1:0]  in_type;
    logic [7:0]  in_val;
    logic        unused_aux;

    assign in_dest    = bus.in_data[WIDTH-1 -: 4];
    assign in_src     = bus.in_data[WIDTH-5 -: 4];
    assign in_type    = bus.in_data[WIDTH-9 -: 2];
    assign in_val     = bus.in_data[7:0];
    assign unused_aux = ^bus.in_data[WIDTH-11:8];

    // One-hot slot the packet would fill; zero means the packet is not one
    // this block can use (wrong dest, type or source, or a residual before
    // any residual exists).
    logic [3:0]  hit;

    always_comb begin
        hit = 4'b0000;
        if (in_dest == SELF_ADDR) begin
            if (in_type == PSUM_TYPE) begin
                if (in_src == SUM1_ADDR)
                    hit = 4'b0001;
                else if (in_src == SUM2_ADDR)
                    hit = 4'b0010;
                else if (in_src == SUM3_ADDR)
                    hit = 4'b0100;
            end else if (in_type == RES_TYPE && in_src == OFM_ADDR && tstep != 4'd0) begin
                hit = 4'b1000;
            end
        end
    end

    logic        in_ready_c;
    logic        xfer_in;
    logic        pkt_ok;
    logic        accept;
    logic        drop;
    logic [3:0]  need_mask;
    logic        mask_full;
    logic        last_pix;

    assign xfer_in   = bus.in_valid && in_ready_c;
    assign pkt_ok    = (hit != 4'b0000) && ((hit & got_mask) == 4'b0000);
    assign accept    = xfer_in && pkt_ok;
    assign drop      = xfer_in && !pkt_ok;
    assign need_mask = (tstep == 4'd0) ? 4'b0111 : 4'b1111;
    assign mask_full = (got_mask == need_mask);
    assign last_pix  = (pix_idx == PIX_LAST) && (tstep == TS_LAST);

    // ------------------------------------------------------------------
    // Fire arithmetic (evaluated while in FIRE, registered on exit)
    // ------------------------------------------------------------------
    logic [9:0]  acc_eff;
    logic        fire_spike;
    logic [9:0]  fire_diff;
    logic [7:0]  fire_resid;

    always_comb begin
        acc_eff    = (acc > LEAK_AMT) ? (acc - LEAK_AMT) : 10'd0;
        fire_spike = (acc_eff >= THR);
        fire_diff  = fire_spike ? (acc_eff - THR) : acc_eff;
        // Residual memory holds 8 bits; anything larger clips to full scale.
        fire_resid = (fire_diff[9:8] != 2'b00) ? 8'hFF : fire_diff[7:0];
    end

    // ------------------------------------------------------------------
    // Outgoing packets
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] spk_pkt;
    logic [WIDTH-1:0] res_pkt;

    assign spk_pkt = {OFM_ADDR, SELF_ADDR, SPIKE_TYPE, 7'b0, pix_idx, 7'b0, spike};
    assign res_pkt = {OFM_ADDR, SELF_ADDR, RES_TYPE, 7'b0, pix_idx, resid};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= COLLECT;
        else
            state <= state_nx;
    end

    // ------------------------------------------------------------------
    // FSM: next state and link outputs
    // ------------------------------------------------------------------
    logic              out_valid_c;
    logic [WIDTH-1:0]  out_data_c;

    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = '0;
        case (state)
            COLLECT: begin
                in_ready_c = 1'b1;
                // Mask is checked from the register, so FIRE follows one
                // cycle after the completing packet lands.
                if (mask_full)
                    state_nx = FIRE;
            end
            FIRE: begin
                state_nx = SEND_SPK;
            end
            SEND_SPK: begin
                out_valid_c = 1'b1;
                out_data_c  = spk_pkt;
                if (bus.out_ready)
                    state_nx = SEND_RES;
            end
            SEND_RES: begin
                out_valid_c = 1'b1;
                out_data_c  = res_pkt;
                if (bus.out_ready)
                    state_nx = last_pix ? DONE_ST : COLLECT;
            end
            DONE_ST: begin
                state_nx = DONE_ST;
            end
            default: begin
                state_nx = COLLECT;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;

    // ------------------------------------------------------------------
    // Datapath and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            got_mask  <= 4'b0000;
            acc       <= 10'd0;
            spike     <= 1'b0;
            resid     <= 8'd0;
            pix_idx   <= 10'd0;
            tstep     <= 4'd0;
            done      <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= drop;

            if (accept) begin
                got_mask <= got_mask | hit;
                acc      <= acc + {2'b00, in_val};
            end

            if (state == FIRE) begin
                spike <= fire_spike;
                resid <= fire_resid;
            end

            if (state == SEND_RES && bus.out_ready) begin
                got_mask <= 4'b0000;
                acc      <= 10'd0;
                if (pix_idx == PIX_LAST) begin
                    pix_idx <= 10'd0;
                    if (tstep == TS_LAST)
                        done <= 1'b1;
                    else
                        tstep <= tstep + 4'd1;
                end else begin
                    pix_idx <= pix_idx + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_neuron_acc.sv
// tb/tb_psum_neuron_acc.sv - directed self-checking bench for psum_neuron_acc
module tb_psum_neuron_acc;

    localparam int W = 35;
    localparam logic [3:0] SELF = 4'b1000;
    localparam logic [3:0] OFM  = 4'b1100;
    localparam logic [3:0] S1   = 4'b0001;
    localparam logic [3:0] S2   = 4'b0011;
    localparam logic [3:0] S3   = 4'b0111;
    localparam logic [1:0] T_PSUM = 2'b01;
    localparam logic [1:0] T_RES  = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] pix_idx;
    logic [3:0] tstep;
    logic       done;
    logic       err_pulse;

    int checks = 0;
    int failures = 0;

    psum_neuron_acc_if #(.WIDTH(W)) bus ();

    psum_neuron_acc #(
        .WIDTH(W),
        .ROWS(2),
        .COLS(2),
        .TIMESTEPS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .pix_idx(pix_idx),
        .tstep(tstep),
        .done(done),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_spk(input logic [9:0] p, input logic s);
        return {OFM, SELF, 2'b11, 7'b0, p, 7'b0, s};
    endfunction

    function automatic logic [W-1:0] exp_res(input logic [9:0] p, input logic [7:0] r);
        return {OFM, SELF, 2'b10, 7'b0, p, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] dst, input logic [3:0] src,
                        input logic [1:0] typ, input logic [7:0] val);
        int n;
        n = 0;
        bus.in_data  = {dst, src, typ, 17'd0, val};
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            failures++;
            $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
        end else begin
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic recv(output logic [W-1:0] d);
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!bus.out_valid) begin
            failures++;
            $display("FAIL recv_timeout out_valid=%0b required=1", bus.out_valid);
            d = '0;
        end else begin
            d = bus.out_data;
            step();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [53:0] got;
        logic [53:0] want;
        rst_n = 1'b0;
        step();
        step();
        got  = {bus.in_ready, bus.out_valid, bus.out_data, pix_idx, tstep, done, err_pulse};
        want = {1'b1, 1'b0, 35'd0, 10'd0, 4'd0, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_state got=%h required=%h", got, want);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fire_basic();
        logic [W-1:0] a;
        logic [W-1:0] b;
        send(SELF, S3, T_PSUM, 8'd15);
        send(SELF, S1, T_PSUM, 8'd20);
        send(SELF, S2, T_PSUM, 8'd30);
        recv(a);
        recv(b);
        checks++;
        if (a !== exp_spk(10'd0, 1'b1)) begin
            failures++;
            $display("FAIL basic_spike got=%h required=%h", a, exp_spk(10'd0, 1'b1));
        end
        checks++;
        if (b !== exp_res(10'd0, 8'd1)) begin
            failures++;
            $display("FAIL basic_resid got=%h required=%h", b, exp_res(10'd0, 8'd1));
        end
        checks++;
        if (pix_idx !== 10'd1) begin
            failures++;
            $display("FAIL basic_pix_adv got=%0d required=1", pix_idx);
        end
    endtask

    task automatic test_latency();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   seen;
        send(SELF, S1, T_PSUM, 8'd10);
        send(SELF, S2, T_PSUM, 8'd10);
        send(SELF, S3, T_PSUM, 8'd10);
        seen[0] = bus.out_valid;
        step();
        seen[1] = bus.out_valid;
        step();
        seen[2] = bus.out_valid;
        checks++;
        if (seen !== 3'b100) begin
            failures++;
            $display("FAIL latency_out_valid got=%b required=100", seen);
        end
        recv(a);
        recv(b);
        checks++;
        if (a !== exp_spk(10'd1, 1'b0)) begin
            failures++;
            $display("FAIL nofire_spike got=%h required=%h", a, exp_spk(10'd1, 1'b0));
        end
        checks++;
        if (b !== exp_res(10'd1, 8'd30)) begin
            failures++;
            $display("FAIL nofire_resid got=%h required=%h", b, exp_res(10'd1, 8'd30));
        end
    endtask

    task automatic test_drop();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [6:0]   errs;
        send(SELF, S1, T_PSUM, 8'd10);
        errs[0] = err_pulse;
        send(SELF, S2, T_PSUM, 8'd20);
        send(SELF, S2, T_PSUM, 8'd99);
        errs[1] = err_pulse;
        step();
        errs[2] = err_pulse;
        send(4'b0100, S3, T_PSUM, 8'd50);
        errs[3] = err_pulse;
        send(SELF, OFM, T_RES, 8'd50);
        errs[4] = err_pulse;
        send(SELF, 4'b1111, T_PSUM, 8'd5);
        errs[5] = err_pulse;
        send(SELF, S3, T_PSUM, 8'd40);
        errs[6] = err_pulse;
        checks++;
        if (errs !== 7'b0111010) begin
            failures++;
            $display("FAIL drop_err_pulses got=%b required=0111010", errs);
        end
        recv(a);
        recv(b);
        checks++;
        if (a !== exp_spk(10'd2, 1'b1)) begin
            failures++;
            $display("FAIL drop_spike got=%h required=%h", a, exp_spk(10'd2, 1'b1));
        end
        checks++;
        if (b !== exp_res(10'd2, 8'd6)) begin
            failures++;
            $display("FAIL drop_resid got=%h required=%h", b, exp_res(10'd2, 8'd6));
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int n;
        send(SELF, S1, T_PSUM, 8'd1);
        send(SELF, S2, T_PSUM, 8'd2);
        send(SELF, S3, T_PSUM, 8'd3);
        n = 0;
        while (!bus.out_valid && n < 10) begin
            step();
            n++;
        end
        held = bus.out_data;
        checks++;
        if (held !== exp_spk(10'd3, 1'b0)) begin
            failures++;
            $display("FAIL stall_first got=%h required=%h", held, exp_spk(10'd3, 1'b0));
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_data} !== {1'b1, 1'b0, held}) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d valid=%0b in_ready=%0b data=%h required valid=1 in_ready=0 data=%h",
                         i, bus.out_valid, bus.in_ready, bus.out_data, held);
            end
        end
        recv(a);
        recv(b);
        checks++;
        if (a !== held || b !== exp_res(10'd3, 8'd6)) begin
            failures++;
            $display("FAIL stall_pair got=%h/%h required=%h/%h", a, b, held, exp_res(10'd3, 8'd6));
        end
        checks++;
        if ({tstep, pix_idx} !== {4'd1, 10'd0}) begin
            failures++;
            $display("FAIL wrap_counters got tstep=%0d pix=%0d required tstep=1 pix=0", tstep, pix_idx);
        end
    endtask

    task automatic test_saturate();
        logic [W-1:0] a;
        logic [W-1:0] b;
        send(SELF, OFM, T_RES, 8'd200);
        send(SELF, S1, T_PSUM, 8'd255);
        send(SELF, S2, T_PSUM, 8'd255);
        send(SELF, S3, T_PSUM, 8'd255);
        recv(a);
        recv(b);
        checks++;
        if (a !== exp_spk(10'd0, 1'b1) || b !== exp_res(10'd0, 8'hFF)) begin
            failures++;
            $display("FAIL saturate got=%h/%h required=%h/%h", a, b, exp_spk(10'd0, 1'b1), exp_res(10'd0, 8'hFF));
        end
    endtask

    task automatic test_need_res();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         any_valid;
        send(SELF, S1, T_PSUM, 8'd30);
        send(SELF, S2, T_PSUM, 8'd30);
        send(SELF, S3, T_PSUM, 8'd3);
        any_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            any_valid = any_valid | bus.out_valid;
        end
        checks++;
        if (any_valid !== 1'b0) begin
            failures++;
            $display("FAIL need_res_wait out_valid=%0b required=0", any_valid);
        end
        send(SELF, OFM, T_RES, 8'd5);
        recv(a);
        recv(b);
        checks++;
        if (a !== exp_spk(10'd1, 1'b1) || b !== exp_res(10'd1, 8'd4)) begin
            failures++;
            $display("FAIL need_res_result got=%h/%h required=%h/%h", a, b, exp_spk(10'd1, 1'b1), exp_res(10'd1, 8'd4));
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        send(SELF, S2, T_PSUM, 8'd0);
        send(SELF, OFM, T_RES, 8'd64);
        send(SELF, S1, T_PSUM, 8'd0);
        send(SELF, S3, T_PSUM, 8'd0);
        recv(a);
        recv(b);
        checks++;
        if (a !== exp_spk(10'd2, 1'b1) || b !== exp_res(10'd2, 8'd0)) begin
            failures++;
            $display("FAIL at_threshold got=%h/%h required=%h/%h", a, b, exp_spk(10'd2, 1'b1), exp_res(10'd2, 8'd0));
        end
        send(SELF, OFM, T_RES, 8'd63);
        send(SELF, S1, T_PSUM, 8'd0);
        send(SELF, S2, T_PSUM, 8'd0);
        send(SELF, S3, T_PSUM, 8'd0);
        recv(a);
        recv(b);
        checks++;
        if (a !== exp_spk(10'd3, 1'b0) || b !== exp_res(10'd3, 8'd63)) begin
            failures++;
            $display("FAIL below_threshold got=%h/%h required=%h/%h", a, b, exp_spk(10'd3, 1'b0), exp_res(10'd3, 8'd63));
        end
        step();
        step();
        checks++;
        if ({done, bus.in_ready, bus.out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL done_state got done/in_ready/out_valid=%b required=100",
                     {done, bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_mid_reset();
        logic [53:0]  got;
        logic [53:0]  want;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send(SELF, S1, T_PSUM, 8'd100);
        send(SELF, S2, T_PSUM, 8'd100);
        rst_n = 1'b0;
        step();
        got  = {bus.in_ready, bus.out_valid, bus.out_data, pix_idx, tstep, done, err_pulse};
        want = {1'b1, 1'b0, 35'd0, 10'd0, 4'd0, 1'b0, 1'b0};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL mid_reset_state got=%h required=%h", got, want);
        end
        rst_n = 1'b1;
        step();
        send(SELF, S1, T_PSUM, 8'd20);
        send(SELF, S2, T_PSUM, 8'd30);
        send(SELF, S3, T_PSUM, 8'd15);
        recv(a);
        recv(b);
        checks++;
        if (a !== exp_spk(10'd0, 1'b1) || b !== exp_res(10'd0, 8'd1)) begin
            failures++;
            $display("FAIL post_reset_pixel got=%h/%h required=%h/%h", a, b, exp_spk(10'd0, 1'b1), exp_res(10'd0, 8'd1));
        end
    endtask

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_fire_basic();
        test_latency();
        test_drop();
        test_stall();
        test_saturate();
        test_need_res();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time_ns=%0t required=finish_before_200000", $time);
        $fatal(1);
    end

endmodule
